// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory and its neighbours.
package instr_mem_pkg;

  // Default geometry
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DEPTH  = 16;

  // Word presented on a fault and after reset
  localparam logic [DEF_DATA_W-1:0] DEF_NOP_WORD = '0;

  // Fetch-port mode
  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_LOAD  = 1'b1
  } state_e;

  // Opcode field values, shared with decode
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1010;
  localparam logic [3:0] OP_BNE = 4'b1110;

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one combinational read
// port whose value the top samples into its output register. No reset, so
// contents survive a pipeline reset.
module instr_mem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Program-load write; callers only strobe we for in-range addresses
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read is unregistered here; the top owns the pipeline register
  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_pipe.sv
// Loadable instruction memory with a one-cycle, valid/ready fetch port.
// Owns the FETCH/LOAD mode register, the handshake, the range check that
// flags faults, flush, and the output register feeding decode.
module instr_mem_pipe
  import instr_mem_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DEF_NOP_WORD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              addr_fault,
  input  logic              flush,
  input  logic              load_mode,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable and the compare
  // stays full-width and unsigned
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  state_e            state;
  logic              in_load;
  logic              fetch_in_rng;
  logic              load_in_rng;
  logic              accept;
  logic              enter_load;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign in_load      = (state == ST_LOAD);
  assign fetch_in_rng = ({1'b0, fetch_addr} < DEPTH_X);
  assign load_in_rng  = ({1'b0, load_addr} < DEPTH_X);

  // Ready never depends on the address, only on mode, flush and slot state
  assign fetch_ready = !in_load && (!instr_valid || instr_ready) && !flush;
  assign accept      = fetch_req && fetch_ready;
  assign enter_load  = !in_load && load_mode;
  assign mem_we      = in_load && load_we && load_in_rng;

  instr_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (load_addr[IDX_W-1:0]),
    .wdata (load_data),
    .raddr (fetch_addr[IDX_W-1:0]),
    .rdata (mem_rdata)
  );

  // Mode register: follows load_mode one edge later, so the first cycle
  // after load_mode drops still rejects fetches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= load_mode ? ST_LOAD : ST_FETCH;
  end

  // Output register: flush and load entry kill the slot, accept refills it,
  // a consume empties it, otherwise everything holds (stall)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      instr       <= NOP_WORD;
      instr_addr  <= '0;
      addr_fault  <= 1'b0;
    end else if (flush || enter_load) begin
      instr_valid <= 1'b0;
    end else if (accept) begin
      instr_valid <= 1'b1;
      instr       <= fetch_in_rng ? mem_rdata : NOP_WORD;
      instr_addr  <= fetch_addr;
      addr_fault  <= !fetch_in_rng;
    end else if (instr_ready) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Directed bench for instr_mem_pipe with a scoreboard of expected words.
module tb_instr_mem_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ready;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_addr;
  logic        addr_fault;
  logic        flush;
  logic        load_mode;
  logic        load_we;
  logic [15:0] load_addr;
  logic [15:0] load_data;

  typedef struct {
    logic [15:0] word;
    logic [15:0] addr;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mdl [16];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  instr_mem_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_addr  (instr_addr),
    .addr_fault  (addr_fault),
    .flush       (flush),
    .load_mode   (load_mode),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // At the falling edge: compare the held word against the scoreboard head,
  // retire it if consumed or flushed, and record any accept happening now.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (instr_valid) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb[0];
        chk("instr", 32'(instr), 32'(e.word));
        chk("instr_addr", 32'(instr_addr), 32'(e.addr));
        chk("addr_fault", 32'(addr_fault), 32'(e.fault));
        if (instr_ready || flush) void'(sb.pop_front());
      end
    end
    if (fetch_req && fetch_ready) begin
      e.addr  = fetch_addr;
      e.fault = (fetch_addr >= 16'd16);
      e.word  = e.fault ? 16'h0000 : mdl[fetch_addr[3:0]];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [15:0] a, input logic [15:0] d);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    if (a < 16'd16) mdl[a[3:0]] = d;
    tick();
    load_we = 1'b0;
  endtask

  task automatic fetch1(input logic [15:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; instr_ready = 1'b1;
    flush = 1'b0; load_mode = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_addr", 32'(instr_addr), 32'h0);
    chk("rst_fault", 32'(addr_fault), 32'd0);
    chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Load phase with guards
    load_mode = 1'b1;
    tick();
    fetch_req = 1'b1; fetch_addr = 16'd0;
    #1 chk("load_fetch_ready", 32'(fetch_ready), 32'd0);
    fetch_req = 1'b0;
    load_word(16'd0, 16'h8410);
    load_word(16'd1, 16'h8720);
    load_word(16'd2, 16'h2123);
    load_word(16'd3, 16'h6000);
    load_word(16'd4, 16'hAAAA);
    load_word(16'd20, 16'h5555);   // out of range, must not alias onto addr 4
    load_word(16'd5, 16'hE000);

    // Leaving load: fetch in the exit cycle is refused
    load_mode = 1'b0; fetch_req = 1'b1; fetch_addr = 16'd0;
    #1 chk("exit_fetch_ready", 32'(fetch_ready), 32'd0);
    tick();
    chk("exit_no_valid", 32'(instr_valid), 32'd0);

    // Back-to-back stream 0..3
    for (int a = 0; a < 4; a++) begin
      fetch_addr = 16'(a);
      tick();
      chk("stream_valid", 32'(instr_valid), 32'd1);
    end
    fetch1(16'd4);
    fetch1(16'd5);
    tick(); tick();

    // Stall hold
    fetch1(16'd2);
    instr_ready = 1'b0; fetch_req = 1'b1; fetch_addr = 16'd3;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_fetch_ready", 32'(fetch_ready), 32'd0);
      chk("stall_instr", 32'(instr), 32'h2123);
      chk("stall_addr", 32'(instr_addr), 32'd2);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("after_stall_addr", 32'(instr_addr), 32'd3);
    tick(); tick();

    // Faults, then a clean fetch
    fetch_req = 1'b1;
    fetch_addr = 16'd16;   tick();
    fetch_addr = 16'hFFFF; tick();
    chk("fault_ffff", 32'(addr_fault), 32'd1);
    fetch_addr = 16'd0;    tick();
    fetch_req = 1'b0;
    tick(); tick();

    // Flush while stalled
    fetch1(16'd1);
    instr_ready = 1'b0; flush = 1'b1; fetch_req = 1'b1; fetch_addr = 16'd2;
    #1 chk("flush_fetch_ready", 32'(fetch_ready), 32'd0);
    tick();
    flush = 1'b0; fetch_req = 1'b0;
    chk("flush_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("flush_no_accept", 32'(instr_valid), 32'd0);
    instr_ready = 1'b1;

    // load_we in FETCH is ignored
    load_we = 1'b1; load_addr = 16'd0; load_data = 16'hFFFF;
    tick();
    load_we = 1'b0;
    fetch1(16'd0);
    tick(); tick();

    // Async reset between edges with a valid word held
    fetch1(16'd3);
    chk("pre_rst_valid", 32'(instr_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_instr", 32'(instr), 32'h0);
    chk("arst_addr", 32'(instr_addr), 32'h0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    fetch1(16'd0);
    tick(); tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
